// File: rtl/nios2_oci_dct_pkg.sv
// Shared state encoding and constants for the DCT capture monitor.
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } dct_state_t;

  localparam int unsigned OVF_MAX = 255;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Circular-buffer FIFO with registered pointers and combinational head read.
module nios2_oci_dct_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign level   = count;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/nios2_oci_dct_monitor.sv
// Debug-capture-trace monitor: captures nonempty trace words into a FIFO until test end.
// Optional per-entry timestamps are enabled by defining NIOS2_OCI_DCT_TIMESTAMP_EN.
module nios2_oci_dct_monitor
  import nios2_oci_dct_pkg::*;
#(
  parameter int unsigned DCT_WIDTH   = 30,
  parameter int unsigned COUNT_WIDTH = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned TS_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dct_valid,
  input  logic [DCT_WIDTH-1:0]      dct_buffer,
  input  logic [COUNT_WIDTH-1:0]    dct_count,
  input  logic                      test_ending,
  input  logic                      test_has_ended,
  input  logic                      rd_ready,
  output logic                      rd_valid,
  output logic [DCT_WIDTH-1:0]      rd_data,
  output logic [COUNT_WIDTH-1:0]    rd_count,
  output logic [TS_WIDTH-1:0]       rd_timestamp,
  output logic [$clog2(DEPTH):0]    fill_level,
  output logic [7:0]                overflow_count,
  output logic [1:0]                state,
  output logic                      done
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  localparam int unsigned EW = TS_WIDTH + DCT_WIDTH + COUNT_WIDTH;
`else
  localparam int unsigned EW = DCT_WIDTH + COUNT_WIDTH;
`endif

  dct_state_t       state_q;
  dct_state_t       state_d;
  logic             sticky_q;
  logic [7:0]       ovf_q;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic [EW-1:0]    wdata;
  logic [EW-1:0]    rdata;
  logic             capturing;
  logic             push_req;
  logic             push;
  logic             pop;

  assign capturing = (state_q == IDLE) || (state_q == CAPTURE);
  assign push_req  = dct_valid && (dct_count != '0) && capturing;
  assign pop       = reset_n && !empty && rd_ready;
  assign push      = push_req && (!full || pop);

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign wdata        = {ts_q, dct_buffer, dct_count};
  assign rd_timestamp = reset_n ? rdata[EW-1 -: TS_WIDTH] : '0;
`else
  assign wdata        = {dct_buffer, dct_count};
  assign rd_timestamp = '0;
`endif

  nios2_oci_dct_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .rdata   (rdata),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sticky_q <= 1'b0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_q | test_has_ended;
      if (push_req && full && !pop && (ovf_q != 8'(OVF_MAX))) begin
        ovf_q <= ovf_q + 1'b1;
      end
    end
  end

  // Test-end requests win over the IDLE->CAPTURE step; the push itself still lands.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, CAPTURE: begin
        if (test_ending || test_has_ended) begin
          state_d = DRAIN;
        end else if (push_req) begin
          state_d = CAPTURE;
        end
      end
      DRAIN: begin
        if ((level == '0) && sticky_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_valid       = reset_n && !empty;
  assign rd_data        = reset_n ? rdata[COUNT_WIDTH +: DCT_WIDTH] : '0;
  assign rd_count       = reset_n ? rdata[COUNT_WIDTH-1:0] : '0;
  assign fill_level     = reset_n ? level : '0;
  assign overflow_count = reset_n ? ovf_q : '0;
  assign state          = reset_n ? 2'(state_q) : '0;
  assign done           = reset_n && (state_q == DONE);

endmodule

// File: tb/tb_nios2_oci_dct_monitor.sv
// Randomized and directed checks of the DCT monitor against a queue-based reference model.
module tb_nios2_oci_dct_monitor;

  localparam int unsigned DW    = 30;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TW    = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          dct_valid;
  logic [DW-1:0] dct_buffer;
  logic [CW-1:0] dct_count;
  logic          test_ending;
  logic          test_has_ended;
  logic          rd_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] rd_count;
  logic [TW-1:0] rd_timestamp;
  logic [4:0]    fill_level;
  logic [7:0]    overflow_count;
  logic [1:0]    state;
  logic          done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [TW-1:0] t;
  } entry_t;

  entry_t      q[$];
  int unsigned m_ovf;
  int unsigned m_state;
  bit          m_sticky;
  int unsigned m_ts;

  nios2_oci_dct_monitor #(
    .DCT_WIDTH   (DW),
    .COUNT_WIDTH (CW),
    .DEPTH       (DEPTH),
    .TS_WIDTH    (TW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_count       (rd_count),
    .rd_timestamp   (rd_timestamp),
    .fill_level     (fill_level),
    .overflow_count (overflow_count),
    .state          (state),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one rising edge, from the current inputs.
  task automatic model_step();
    bit          pop;
    bit          want;
    int unsigned size_before;
    entry_t      e;
    if (!reset_n) begin
      q.delete();
      m_ovf    = 0;
      m_state  = 0;
      m_sticky = 0;
      m_ts     = 0;
      return;
    end
    size_before = q.size();
    pop  = (q.size() > 0) && rd_ready;
    want = dct_valid && (dct_count != 0) && (m_state <= 1);
    if (pop) void'(q.pop_front());
    if (want) begin
      if (q.size() < DEPTH) begin
        e.d = dct_buffer;
        e.c = dct_count;
        e.t = TW'(m_ts);
        q.push_back(e);
      end else if (m_ovf < 255) begin
        m_ovf++;
      end
    end
    if (m_state <= 1 && (test_ending || test_has_ended)) m_state = 2;
    else if (m_state == 0 && want) m_state = 1;
    else if (m_state == 2 && size_before == 0 && m_sticky) m_state = 3;
    m_sticky = m_sticky | test_has_ended;
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic compare_all();
    logic [TW-1:0] exp_ts;
    check("rd_valid", rd_valid, q.size() > 0);
    if (q.size() > 0) begin
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
      exp_ts = q[0].t;
`else
      exp_ts = '0;
`endif
      check("rd_data", rd_data, q[0].d);
      check("rd_count", rd_count, q[0].c);
      check("rd_timestamp", rd_timestamp, exp_ts);
    end
    check("fill_level", fill_level, q.size());
    check("overflow_count", overflow_count, m_ovf);
    check("state", state, m_state);
    check("done", done, m_state == 3);
  endtask

  // Drive inputs, advance past one rising edge, then compare at the falling edge.
  task automatic cycle(input bit rst, input bit v, input logic [DW-1:0] b, input logic [CW-1:0] c,
                       input bit te, input bit th, input bit rdy);
    reset_n        = ~rst;
    dct_valid      = v;
    dct_buffer     = b;
    dct_count      = c;
    test_ending    = te;
    test_has_ended = th;
    rd_ready       = rdy;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, '0, 0, 0, 0);
    cycle(1, 1, 30'h3, 4'h2, 1, 1, 1);
  endtask

  initial begin
    logic [TW-1:0] ts_a;
    logic [TW-1:0] ts_b;

    do_reset();
    check("reset_fill", fill_level, 0);
    check("reset_state", state, 0);
    check("reset_valid", rd_valid, 0);

    // First push: visible one cycle later.
    cycle(0, 1, 30'h1234567, 4'd3, 0, 0, 0);
    check("first_valid", rd_valid, 1);
    check("first_data", rd_data, 30'h1234567);
    check("first_count", rd_count, 3);
    check("first_state", state, 1);

    // Overfill without popping.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(0, 1, DW'(32'h100 + i), 4'd1, 0, 0, 0);
    check("full_level", fill_level, 16);
    check("full_ovf", overflow_count, 4);

    // Push with pop while full.
    cycle(0, 1, 30'h2aa, 4'd5, 0, 0, 1);
    check("fullpop_level", fill_level, 16);
    check("fullpop_ovf", overflow_count, 4);
    check("fullpop_head", rd_data, 30'h101);
    for (int i = 0; i < 16; i++) cycle(0, 0, '0, '0, 0, 0, 1);
    check("fullpop_drained", fill_level, 0);

    // Drain sequence.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 1, DW'(32'h200 + i), 4'd2, 0, 0, 0);
    cycle(0, 0, '0, '0, 1, 0, 0);
    check("drain_state", state, 2);
    cycle(0, 0, '0, '0, 0, 1, 0);
    cycle(0, 0, '0, '0, 0, 0, 1);
    cycle(0, 0, '0, '0, 0, 0, 1);
    cycle(0, 0, '0, '0, 0, 0, 1);
    check("drain_empty", fill_level, 0);
    check("drain_not_done", done, 0);
    cycle(0, 0, '0, '0, 0, 0, 0);
    check("drain_done", done, 1);
    check("done_state", state, 3);
    cycle(0, 1, 30'h5, 4'd1, 0, 0, 0);
    check("done_sticks", done, 1);
    check("done_no_push", fill_level, 0);

    // Empty words, push on the transition edge, pushes during drain.
    do_reset();
    cycle(0, 1, 30'h300, 4'd0, 0, 0, 0);
    check("zero_count_fill", fill_level, 0);
    check("zero_count_state", state, 0);
    cycle(0, 1, 30'h301, 4'd4, 0, 0, 0);
    cycle(0, 1, 30'h302, 4'd4, 1, 0, 0);
    check("edge_push_fill", fill_level, 2);
    for (int i = 0; i < 4; i++) cycle(0, 1, 30'h303, 4'd7, 0, 0, 0);
    check("drain_push_fill", fill_level, 2);
    check("drain_push_ovf", overflow_count, 0);

    // Timestamps 18 cycles apart.
    do_reset();
    cycle(0, 1, 30'h400, 4'd1, 0, 0, 0);
    for (int i = 0; i < 17; i++) cycle(0, 0, '0, '0, 0, 0, 0);
    cycle(0, 1, 30'h401, 4'd1, 0, 0, 0);
    ts_a = rd_timestamp;
    cycle(0, 0, '0, '0, 0, 0, 1);
    ts_b = rd_timestamp;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    check("ts_delta", TW'(ts_b - ts_a), 2);
`else
    check("ts_zero", {ts_a, ts_b}, 0);
`endif

    // Randomized traffic with occasional resets and test-end events.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 7,
            DW'($urandom),
            CW'($urandom),
            $urandom_range(0, 199) == 0,
            $urandom_range(0, 249) == 0,
            $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
